// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: latches hall/car calls into a pending bitmap
// and runs a SCAN (collective) policy to pick the next floor for the
// downstream floor controller. It retires a call once the door has cycled at
// that floor. A door that never opens is retired by timeout and raises a
// sticky fault.

// Per-floor call latch. A retire of this floor wins over a new call on the same edge.
module elevator_request_scheduler_floor #(
  parameter int FLOOR_IDX = 0,
  parameter int FLOOR_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               call,
  input  logic               clr_cur,
  input  logic [FLOOR_W-1:0] current_floor,
  output logic               cur_hit,
  output logic               pend
);
  assign cur_hit = (current_floor == FLOOR_W'(FLOOR_IDX));

  // Capture the call and drop it when the scheduler retires the current floor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else     pend <= (pend | call) & ~(clr_cur & cur_hit);
  end
endmodule

module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = 2,
  parameter int DOOR_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_status,
  output logic [FLOOR_W-1:0]    floor_select,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy,
  output logic                  fault
);
  localparam int TMR_W = 8;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, SERVE} state_t;

  state_t                  state, state_next;
  logic [FLOOR_W-1:0]      floor_select_next;
  logic                    dir_up_next;
  logic                    clr_cur;
  logic [TMR_W-1:0]        timer;
  logic                    opened;
  logic [NUM_FLOORS-1:0]   cur_hit;
  logic [FLOOR_W-1:0]      above, below;
  logic                    have_above, have_below;
  logic                    cur_pending, cur_is_target;
  logic                    door_expired, serve_done;
  logic                    pick_up, pick_down;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_floor
    elevator_request_scheduler_floor #(
      .FLOOR_IDX (g),
      .FLOOR_W   (FLOOR_W)
    ) u_floor (
      .clk           (clk),
      .rst           (rst),
      .call          (call_req[g]),
      .clr_cur       (clr_cur),
      .current_floor (current_floor),
      .cur_hit       (cur_hit[g]),
      .pend          (pending[g])
    );
  end

  // A current_floor beyond the last floor hits no bit, so it never matches.
  assign cur_pending   = |(pending & cur_hit);
  assign cur_is_target = (floor_select == current_floor);

  // Nearest pending floor strictly above (lowest) and strictly below (highest).
  always_comb begin
    above      = '0;
    have_above = 1'b0;
    below      = '0;
    have_below = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
        above      = FLOOR_W'(i);
        have_above = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
        below      = FLOOR_W'(i);
        have_below = 1'b1;
      end
    end
  end

  // Direction choice: keep heading the current way, else reverse.
  assign pick_up   = have_above & (dir_up | ~have_below);
  assign pick_down = have_below & (~dir_up | ~have_above);

  // The door is given up on when the last allowed closed-door cycle elapses.
  assign door_expired = (state == SERVE) & ~door_status & ~opened &
                        (timer == TMR_W'(DOOR_TIMEOUT - 1));
  assign serve_done   = (state == SERVE) & ~door_status & (opened | door_expired);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: SCAN travel, serve at target, decide on SERVE exit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cur_pending)    state_next = cur_is_target ? IDLE : SERVE;
        else if (pick_up)   state_next = MOVE_UP;
        else if (pick_down) state_next = MOVE_DOWN;
      end
      MOVE_UP: begin
        if (cur_is_target)    state_next = SERVE;
        else if (!have_above) state_next = IDLE;
      end
      MOVE_DOWN: begin
        if (cur_is_target)    state_next = SERVE;
        else if (!have_below) state_next = IDLE;
      end
      SERVE: begin
        if (serve_done) begin
          if (pick_up)        state_next = MOVE_UP;
          else if (pick_down) state_next = MOVE_DOWN;
          else                state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: target floor, direction and current-floor retire strobe.
  always_comb begin
    floor_select_next = floor_select;
    dir_up_next       = dir_up;
    clr_cur           = 1'b0;
    case (state)
      IDLE: begin
        if (cur_pending) begin
          // Already parked here with the door done: absorb the call silently.
          if (cur_is_target) clr_cur = 1'b1;
          else               floor_select_next = current_floor;
        end else if (pick_up) begin
          floor_select_next = above;
          dir_up_next       = 1'b1;
        end else if (pick_down) begin
          floor_select_next = below;
          dir_up_next       = 1'b0;
        end
      end
      MOVE_UP: begin
        if (!cur_is_target && have_above) floor_select_next = above;
      end
      MOVE_DOWN: begin
        if (!cur_is_target && have_below) floor_select_next = below;
      end
      SERVE: begin
        clr_cur = door_status | serve_done;
        if (serve_done) begin
          if (pick_up) begin
            floor_select_next = above;
            dir_up_next       = 1'b1;
          end else if (pick_down) begin
            floor_select_next = below;
            dir_up_next       = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs plus the door timer and opened flag used in SERVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      floor_select <= '0;
      dir_up       <= 1'b1;
      busy         <= 1'b0;
      fault        <= 1'b0;
      timer        <= '0;
      opened       <= 1'b0;
    end else begin
      floor_select <= floor_select_next;
      dir_up       <= dir_up_next;
      busy         <= (state_next != IDLE);
      if (door_expired) fault <= 1'b1;
      if (state != SERVE) begin
        timer  <= '0;
        opened <= 1'b0;
      end else if (door_status) begin
        opened <= 1'b1;
      end else if (!opened && !door_expired) begin
        timer  <= timer + 1'b1;
      end
    end
  end
endmodule
